instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised instruction sequencer. It bundles instruction storage, a programmable-rate tick generator and a program counter into one block, and adds a loop-end address, run/stop control and single-step. Instructions are loaded and configured while stopped. In run mode it replays memory from address 0 up to a programmable last address, then wraps. Each emitted instruction is a registered word with a one-cycle valid strobe, consumed by the downstream execution logic.

## Interface
- DATA_W, 4: instruction word width.
- ADDR_W, 4: address width; memory depth is 2**ADDR_W.
- RATE_W, 3: width of rate configuration; emit period is cfg_rate+1 cycles.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write wr_data to memory at wr_addr (honoured in IDLE only).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- cfg_en  in  1  load cfg_rate and cfg_last (honoured in IDLE only).
- cfg_rate  in  RATE_W  emit period minus one.
- cfg_last  in  ADDR_W  last address of the program loop.
- start  in  1  enter RUN from address 0.
- stop  in  1  return to IDLE, pc retained.
- step  in  1  in IDLE, emit one instruction at pc and advance.
- instr  out  DATA_W  registered instruction word.
- instr_valid  out  1  one-cycle strobe qualifying instr.
- pc  out  ADDR_W  address of the next instruction to emit.
- running  out  1  high while in RUN.

## Operation
- **Reset values**
  - Outputs: state IDLE, pc=0, instr=0, instr_valid=0, running=0.
  - Internal: rate_q=0, last_q=all ones, prescaler count=0.
  - Memory contents are not reset.
- **FSM states:** IDLE and RUN.
- **Priority in every cycle:** rst > stop > start > step.
- **IDLE**
  - wr_en writes mem[wr_addr].
  - cfg_en loads rate_q and last_q.
  - start: go to RUN with pc=0 and prescaler count=0.
  - step: instr<=mem[pc], instr_valid<=1, pc advances.
- **RUN**
  - wr_en and cfg_en are ignored, with no side effect.
  - The prescaler counts 0..rate_q. The cycle where count==rate_q is a tick, and the count returns to 0.
  - On a tick: instr<=mem[pc], instr_valid<=1, pc advances.
  - stop: go to IDLE. pc keeps its value and the prescaler clears. A tick in the same cycle as stop is suppressed.
  - start while already in RUN restarts: pc=0, count=0.
- **pc advance:** if pc==last_q then pc<=0, else pc<=pc+1. Arithmetic is modulo 2**ADDR_W.
- **pc beyond last_q:** if pc>last_q (last_q was lowered after a stop), pc counts up to all ones, wraps to 0 and then obeys last_q.
- **Read/write collision:** step with wr_en to the same address in the same cycle returns the old contents, then the write lands.
- **cfg_en with step in the same cycle:** both take effect; the step uses the old last_q.

## Timing
- **Start:** asserted in cycle N puts running=1 in N+1. The first tick is in cycle N+1+rate_q. instr_valid is high in cycle N+2+rate_q with instr=mem[0].
- **Steady RUN:** instr_valid pulses every rate_q+1 cycles. With rate_q=0 it is high every cycle.
- **Step:** asserted in cycle N gives instr_valid in cycle N+1. pc updates in N+1.
- **Stop:** asserted in cycle N gives running=0 in N+1 and no instr_valid in N+1.
- **Reset mid-run:** asserted in cycle N clears all outputs in N+1. Any start, step or tick in cycle N is discarded.
- **instr between strobes:** holds its last value.

## Structure
- Shared package seq_pkg holds:
  - the state enum {ST_IDLE, ST_RUN};
  - the default constants DEF_RATE=0 and DEF_LAST='1.
- One sub-module, rate_prescaler: RATE_W counter with clear, enable and period input, producing a one-cycle tick.
- Memory is an inferred synchronous-write array inside instr_sequencer.

## Test plan
- Reset check: assert rst for 2 cycles. Required: instr=0, instr_valid=0, pc=0, running=0; a step with no cfg walks pc up to 15 and wraps to 0.
- Full-rate loop: write mem[0..3]=1,2,3,4, cfg_rate=0, cfg_last=3, start. Required: valid every cycle, instr sequence 1,2,3,4,1,2,…; first valid 2 cycles after start.
- Slow rate: same program with cfg_rate=2. Required: valid every 3 cycles; first valid 4 cycles after start.
- Stop and step: stop when pc=2, then step, step. Required: instr=3 with pc=3, then instr=4 with pc=0 (wrap at last=3).
- Writes blocked in RUN: issue wr_en to addr 1 with data F and cfg_en with rate 5 during RUN. Required: sequence unchanged, period unchanged; after stop, step at addr 1 returns 2.
- Reset precedence: assert rst mid-run in the same cycle as start and step. Required: next cycle IDLE with all outputs 0 and no instr_valid.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types and reset constants for the instruction sequencer.
package seq_pkg;

    // Sequencer operating modes
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Default configuration applied on reset (sliced to width at use site)
    localparam logic [31:0] DEF_RATE = '0;
    localparam logic [31:0] DEF_LAST = '1;

endpackage

// File: rtl/instr_sequencer_if.sv
// Load/config/control inputs and instruction output bundle.
interface instr_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int RATE_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cfg_en;
    logic [RATE_W-1:0] cfg_rate;
    logic [ADDR_W-1:0] cfg_last;
    logic              start;
    logic              stop;
    logic              step;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              running;

    // Controller / testbench side
    modport master (
        output wr_en, wr_addr, wr_data, cfg_en, cfg_rate, cfg_last,
               start, stop, step,
        input  instr, instr_valid, pc, running
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_addr, wr_data, cfg_en, cfg_rate, cfg_last,
               start, stop, step,
        output instr, instr_valid, pc, running
    );
endinterface

// File: rtl/instr_sequencer_rate_prescaler.sv
// Programmable-period counter: counts 0..period and flags a tick on the
// cycle the count equals period, then returns to 0.
module rate_prescaler #(
    parameter int RATE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RATE_W-1:0] period,
    output logic              tick
);
    logic [RATE_W-1:0] cnt_q, cnt_d;

    // A clear wins over a tick so a stop/restart never emits in its own cycle
    assign tick = en && !clr && (cnt_q == period);

    // Next count: clear, wrap on tick, or advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: program memory, rate prescaler and program counter.
// Loads/config happen in IDLE; RUN replays mem[0..last] at the programmed
// rate, and IDLE also supports single-step.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int RATE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [ADDR_W-1:0] last_q, last_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              is_idle;
    logic              pre_clr;
    logic              pre_tick;
    logic [ADDR_W-1:0] pc_next;

    assign is_idle = (state_q == ST_IDLE);
    // Counter sits at 0 whenever stopped so each start gets a full first period
    assign pre_clr = is_idle || bus.stop || bus.start;
    assign pc_next = (pc_q == last_q) ? '0 : pc_q + 1'b1;
    assign mem_we  = is_idle && bus.wr_en && !rst;

    rate_prescaler #(.RATE_W(RATE_W)) u_pre (
        .clk    (clk),
        .rst    (rst),
        .clr    (pre_clr),
        .en     (!is_idle),
        .period (rate_q),
        .tick   (pre_tick)
    );

    // Program store: write-only port, read is asynchronous so a same-cycle
    // step sees the old word
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[bus.wr_addr] <= bus.wr_data;
    end

    // Next state, pc and emit logic; priority stop > start > step/tick
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        rate_d  = rate_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_en) begin
                    rate_d = bus.cfg_rate;
                    last_d = bus.cfg_last;
                end
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end else if (bus.step) begin
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    pc_d    = pc_next;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    pc_d = '0;
                end else if (pre_tick) begin
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    pc_d    = pc_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            rate_q  <= DEF_RATE[RATE_W-1:0];
            last_q  <= DEF_LAST[ADDR_W-1:0];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            rate_q  <= rate_d;
            last_q  <= last_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.running     = (state_q == ST_RUN);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    instr_sequencer_if #(.DATA_W(4), .ADDR_W(4), .RATE_W(3)) bus ();

    instr_sequencer #(.DATA_W(4), .ADDR_W(4), .RATE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance one edge; outputs are sampled 1 time unit later
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        clk1();
        bus.step = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] rate, input logic [3:0] last);
        bus.cfg_en = 1'b1; bus.cfg_rate = rate; bus.cfg_last = last;
        clk1();
        bus.cfg_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.cfg_en = 0; bus.cfg_rate = 0; bus.cfg_last = 0;
        bus.start = 0; bus.stop = 0; bus.step = 0;

        // Reset
        rst = 1; clk1(); clk1(); rst = 0;
        chk("rst_instr", bus.instr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_running", bus.running, 0);

        // Step with default last=15: pc walks 1..15 then 0
        for (int i = 0; i < 16; i++) begin
            do_step();
            chk("walk_valid", bus.instr_valid, 1);
            chk("walk_pc", bus.pc, (i + 1) % 16);
        end
        clk1();
        chk("walk_idle_valid", bus.instr_valid, 0);

        // Program mem[0..3]=1..4, full rate, loop end 3
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = 4'(i + 1);
            clk1();
        end
        bus.wr_en = 0;
        cfg(3'd0, 4'd3);
        bus.start = 1; clk1(); bus.start = 0;
        chk("fr_running", bus.running, 1);
        chk("fr_first_valid", bus.instr_valid, 0);
        for (int k = 0; k < 6; k++) begin
            clk1();
            chk("fr_valid", bus.instr_valid, 1);
            chk("fr_instr", bus.instr, (k % 4) + 1);
            chk("fr_pc", bus.pc, (k + 1) % 4);
        end

        // Stop at pc=2 (tick in that cycle suppressed), then two steps
        bus.stop = 1; clk1(); bus.stop = 0;
        chk("stop_running", bus.running, 0);
        chk("stop_valid", bus.instr_valid, 0);
        chk("stop_pc", bus.pc, 2);
        do_step();
        chk("st1_instr", bus.instr, 3);
        chk("st1_pc", bus.pc, 3);
        do_step();
        chk("st2_instr", bus.instr, 4);
        chk("st2_pc", bus.pc, 0);
        chk("st2_valid", bus.instr_valid, 1);

        // Slow rate with blocked write/config mid-run
        cfg(3'd2, 4'd3);
        bus.start = 1; clk1(); bus.start = 0;
        chk("sr_running", bus.running, 1);
        for (int j = 1; j <= 12; j++) begin
            if (j == 4) begin
                bus.wr_en = 1; bus.wr_addr = 4'd1; bus.wr_data = 4'hF;
                bus.cfg_en = 1; bus.cfg_rate = 3'd5; bus.cfg_last = 4'd0;
            end else begin
                bus.wr_en = 0; bus.cfg_en = 0;
            end
            clk1();
            chk("sr_valid", bus.instr_valid, (j % 3 == 0) ? 1 : 0);
            if (j % 3 == 0) begin
                chk("sr_instr", bus.instr, ((j / 3 - 1) % 4) + 1);
                chk("sr_pc", bus.pc, (j / 3) % 4);
            end
        end
        bus.wr_en = 0; bus.cfg_en = 0;
        bus.stop = 1; clk1(); bus.stop = 0;
        chk("sr_stop_running", bus.running, 0);
        chk("sr_stop_pc", bus.pc, 0);
        do_step();
        chk("blk_instr0", bus.instr, 1);
        chk("blk_pc1", bus.pc, 1);
        do_step();
        chk("blk_instr1", bus.instr, 2);
        chk("blk_pc2", bus.pc, 2);

        // Reset wins over start and step mid-run
        bus.start = 1; clk1(); bus.start = 0;
        clk1(); clk1(); clk1();
        rst = 1; bus.start = 1; bus.step = 1;
        clk1();
        rst = 0; bus.start = 0; bus.step = 0;
        chk("rp_instr", bus.instr, 0);
        chk("rp_valid", bus.instr_valid, 0);
        chk("rp_pc", bus.pc, 0);
        chk("rp_running", bus.running, 0);
        clk1();
        chk("rp_valid2", bus.instr_valid, 0);
        chk("rp_running2", bus.running, 0);

        // Read/write collision returns old word
        bus.wr_en = 1; bus.wr_addr = 4'd0; bus.wr_data = 4'd9;
        do_step();
        bus.wr_en = 0;
        chk("col_instr", bus.instr, 1);
        chk("col_pc", bus.pc, 1);
        do_step();
        do_step();
        chk("col_instr3", bus.instr, 3);
        chk("col_pc3", bus.pc, 3);

        // cfg with step: step uses old last (15), so pc goes to 4, not 0
        bus.cfg_en = 1; bus.cfg_rate = 3'd0; bus.cfg_last = 4'd3;
        do_step();
        bus.cfg_en = 0;
        chk("cs_instr", bus.instr, 4);
        chk("cs_pc", bus.pc, 4);

        // pc beyond last climbs to 15, wraps, then obeys last=3
        for (int i = 0; i < 12; i++) begin
            do_step();
            chk("bl_pc", bus.pc, (5 + i) % 16);
        end
        do_step();
        chk("bl_new_instr", bus.instr, 9);
        chk("bl_new_pc", bus.pc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
